// File: rtl/esp32_spi_master.sv
// esp32_spi_master: SPI mode 0 master (CPOL=0, CPHA=0), 8-bit words, MSB first.
// Bytes arrive on a valid/ready stream. tx_last closes the CS frame after the
// byte it travels with.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | CS high, ready for the first byte of a new transaction
// S_SETUP | CS low, SCLK low, CS-to-first-edge setup delay
// S_SHIFT | 8 bit slots: CLK_DIV cycles low, then CLK_DIV cycles high
// S_NEXT  | CS low, SCLK low, waiting as long as needed for the next byte
// S_HOLD  | CS low after the last high phase, hold delay before CS rises
// S_GAP   | CS high, minimum idle time before the next transaction
module esp32_spi_master #(
    parameter int CLK_DIV  = 5,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk_sys,
    input  logic       rst,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] IDLE_LD  = CW'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_NEXT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    // Bit 7 of the TX byte goes straight to MOSI on accept, so only the
    // remaining seven bits are queued. RX keeps seven bits because the
    // eighth is merged from the synchronizer when the byte completes.
    logic [6:0]    r_tx_sh, w_tx_sh_nxt;
    logic [6:0]    r_rx_sh, w_rx_sh_nxt;
    logic          r_last, w_last_nxt;
    logic          r_cs_n, w_cs_n_nxt;
    logic          r_sclk, w_sclk_nxt;
    logic          r_mosi, w_mosi_nxt;
    logic [7:0]    r_rx_data, w_rx_data_nxt;
    logic          r_rx_valid, w_rx_valid_nxt;
    logic          r_miso_s1, r_miso_s2;
    logic          w_cnt_zero;
    logic          w_rdy_state;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_rdy_state = (r_state == S_IDLE) || (r_state == S_NEXT);

    // Two-flop synchronizer for the asynchronous MISO input
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= spi_miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // State and datapath registers; reset discards any partial byte
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_last     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_rx_sh    <= w_rx_sh_nxt;
            r_last     <= w_last_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_sclk     <= w_sclk_nxt;
            r_mosi     <= w_mosi_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    // Next-state and next-datapath logic; every register holds unless changed
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_nxt      = r_bit;
        w_tx_sh_nxt    = r_tx_sh;
        w_rx_sh_nxt    = r_rx_sh;
        w_last_nxt     = r_last;
        w_cs_n_nxt     = r_cs_n;
        w_sclk_nxt     = r_sclk;
        w_mosi_nxt     = r_mosi;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_tx_sh_nxt = tx_data[6:0];
                    w_last_nxt  = tx_last;
                    w_mosi_nxt  = tx_data[7];
                    w_cs_n_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = SETUP_LD;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt   = DIV_LD;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_SHIFT: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!r_sclk) begin
                    w_sclk_nxt = 1'b1;
                    w_cnt_nxt  = DIV_LD;
                end else begin
                    // Last cycle of the high phase: sample, then drop SCLK
                    w_sclk_nxt  = 1'b0;
                    w_rx_sh_nxt = {r_rx_sh[5:0], r_miso_s2};
                    if (r_bit == 3'd7) begin
                        w_rx_data_nxt  = {r_rx_sh, r_miso_s2};
                        w_rx_valid_nxt = 1'b1;
                        if (r_last) begin
                            w_cnt_nxt   = HOLD_LD;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_state_nxt = S_NEXT;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_mosi_nxt  = r_tx_sh[6];
                        w_tx_sh_nxt = {r_tx_sh[5:0], 1'b0};
                        w_cnt_nxt   = DIV_LD;
                    end
                end
            end
            S_NEXT: begin
                if (tx_valid) begin
                    w_tx_sh_nxt = tx_data[6:0];
                    w_last_nxt  = tx_last;
                    w_mosi_nxt  = tx_data[7];
                    w_bit_nxt   = '0;
                    w_cnt_nxt   = DIV_LD;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_cs_n_nxt  = 1'b1;
                    w_cnt_nxt   = IDLE_LD;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign spi_clk  = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid & ~rst;
    assign tx_ready = w_rdy_state & ~rst;
    assign busy     = (r_state != S_IDLE);

endmodule
